// File: rtl/mem_access_if.sv
// Request/response and data-memory signals of the load/store unit, grouped as one bus.
// The slave side is the unit; the master side is the core pipeline plus data memory.
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        dm_memread;
    logic        dm_memwrite;
    logic [1:0]  dm_datatype;
    logic [31:0] dm_addr;
    logic [31:0] dm_writedata;
    logic [31:0] dm_rdata;

    logic        rsp_valid;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_load, req_funct3, req_addr, req_wdata, req_rd, dm_rdata,
        output req_ready, dm_memread, dm_memwrite, dm_datatype, dm_addr, dm_writedata,
        output rsp_valid, rsp_rd, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_load, req_funct3, req_addr, req_wdata, req_rd, dm_rdata,
        input  req_ready, dm_memread, dm_memwrite, dm_datatype, dm_addr, dm_writedata,
        input  rsp_valid, rsp_rd, rsp_data, rsp_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// RISC-V load/store unit: one request at a time, single-cycle Dmem strobe,
// lane selection and sign/zero extension of load data, error response for bad requests.
module mem_access_unit (
    input  logic         clk,
    input  logic         rst_n,
    mem_access_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    state_e      state_q;
    logic        load_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  rd_q;

    logic        dm_memread_q;
    logic        dm_memwrite_q;
    logic [1:0]  dm_datatype_q;
    logic [31:0] dm_addr_q;
    logic [31:0] dm_writedata_q;

    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [4:0]  rsp_rd_q;
    logic [31:0] rsp_data_q;

    logic        req_legal;
    logic        req_misaligned;
    logic        req_bad;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_result;

    always_comb begin
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        if (bus.req_load) begin
            req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                        (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                        (bus.req_funct3 == 3'b101);
        end else begin
            req_legal = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11);
        end
        case (bus.req_funct3[1:0])
            2'b01:   req_misaligned = bus.req_addr[0];
            2'b10:   req_misaligned = (bus.req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
        req_bad = !req_legal || req_misaligned;
    end

    // Lane extraction works on the request captured at accept time.
    always_comb begin
        case (addr_lo_q)
            2'd0:    byte_lane = bus.dm_rdata[7:0];
            2'd1:    byte_lane = bus.dm_rdata[15:8];
            2'd2:    byte_lane = bus.dm_rdata[23:16];
            default: byte_lane = bus.dm_rdata[31:24];
        endcase
        half_lane = addr_lo_q[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
        case (funct3_q)
            3'b000:  load_result = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_result = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_result = {24'h0, byte_lane};
            3'b101:  load_result = {16'h0, half_lane};
            default: load_result = bus.dm_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            load_q         <= 1'b0;
            funct3_q       <= 3'b000;
            addr_lo_q      <= 2'b00;
            rd_q           <= 5'd0;
            dm_memread_q   <= 1'b0;
            dm_memwrite_q  <= 1'b0;
            dm_datatype_q  <= 2'b00;
            dm_addr_q      <= 32'h0;
            dm_writedata_q <= 32'h0;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_rd_q       <= 5'd0;
            rsp_data_q     <= 32'h0;
        end else begin
            // Strobes and response fields are zero unless set for the next state below.
            dm_memread_q   <= 1'b0;
            dm_memwrite_q  <= 1'b0;
            dm_datatype_q  <= 2'b00;
            dm_addr_q      <= 32'h0;
            dm_writedata_q <= 32'h0;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_rd_q       <= 5'd0;
            rsp_data_q     <= 32'h0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        load_q    <= bus.req_load;
                        funct3_q  <= bus.req_funct3;
                        addr_lo_q <= bus.req_addr[1:0];
                        rd_q      <= bus.req_rd;
                        if (req_bad) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rd_q    <= bus.req_load ? bus.req_rd : 5'd0;
                        end else begin
                            state_q        <= StAccess;
                            dm_memread_q   <= bus.req_load;
                            dm_memwrite_q  <= !bus.req_load;
                            dm_datatype_q  <= bus.req_funct3[1:0];
                            dm_addr_q      <= bus.req_addr;
                            dm_writedata_q <= bus.req_wdata;
                        end
                    end
                end
                StAccess: begin
                    if (load_q) begin
                        state_q <= StWait;
                    end else begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                    end
                end
                StWait: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    rsp_rd_q    <= rd_q;
                    rsp_data_q  <= load_result;
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready    = (state_q == StIdle);
    assign bus.dm_memread   = dm_memread_q;
    assign bus.dm_memwrite  = dm_memwrite_q;
    assign bus.dm_datatype  = dm_datatype_q;
    assign bus.dm_addr      = dm_addr_q;
    assign bus.dm_writedata = dm_writedata_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.rsp_rd       = rsp_rd_q;
    assign bus.rsp_data     = rsp_data_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports, in this order: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have: req_valid in 1, request present; req_ready out 1, request accepted when both high at a clk edge.
REQ-003 SHALL have: req_load in 1, 1=load, 0=store; req_funct3 in 3, RISC-V width code; req_addr in 32, byte address; req_wdata in 32, store data; req_rd in 5, load destination register.
REQ-004 SHALL have the Dmem side: dm_memread out 1; dm_memwrite out 1; dm_datatype out 2 (0=byte, 1=half, 2=word); dm_addr out 32; dm_writedata out 32; dm_rdata in 32, registered Dmem read data.
REQ-005 SHALL have: rsp_valid out 1, one-cycle completion pulse; rsp_rd out 5; rsp_data out 32, aligned/extended load result; rsp_err out 1, misaligned or illegal request.

Function
REQ-006 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP; req_ready=1 only in IDLE.
REQ-007 SHALL, in IDLE with req_valid=1, register all req_* fields, decode, and transition at that edge.
REQ-008 SHALL treat as legal: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all other codes are illegal.
REQ-009 SHALL treat as misaligned: half with addr[0]=1; word with addr[1:0]!=0; byte is never misaligned.
REQ-010 SHALL, for illegal or misaligned requests, go IDLE->RESP directly, never assert dm_memread/dm_memwrite, and give rsp_err=1 and rsp_data=0.
REQ-011 SHALL, for a legal request, go IDLE->ACCESS; in ACCESS, drive dm_addr=req_addr, dm_datatype from funct3[1:0], and dm_writedata=req_wdata unshifted.
REQ-012 SHALL, in ACCESS, assert exactly one of dm_memread (load) or dm_memwrite (store) for exactly one cycle; both SHALL be 0 in every other state.
REQ-013 SHALL, for a store, go ACCESS->RESP; for a load, go ACCESS->WAIT->RESP.
REQ-014 SHALL, in WAIT, sample dm_rdata at the closing edge; it is valid during WAIT because Dmem registers read data on the ACCESS-cycle edge.
REQ-015 SHALL select the byte lane as dm_rdata[8*addr[1:0]+7 : 8*addr[1:0]] and the half lane as dm_rdata[16*addr[1]+15 : 16*addr[1]]; word uses dm_rdata unchanged.
REQ-016 SHALL sign-extend for LB and LH and zero-extend for LBU and LHU, giving a 32-bit result.
REQ-017 SHALL, in RESP, assert rsp_valid for one cycle with rsp_rd=req_rd; stores SHALL give rsp_data=0 and rsp_rd=0; RESP->IDLE unconditionally.
REQ-018 SHALL hold rsp_data, rsp_rd and rsp_err stable, and zero them, whenever rsp_valid=0.
REQ-019 SHALL have latency from accept edge to rsp_valid high of 3 cycles for loads, 2 for stores, and 1 for error requests; throughput SHALL be one request per latency+1 cycles.
REQ-020 SHALL ignore req_valid outside IDLE; upstream holds its request until req_ready=1.
REQ-021 SHALL apply the same lane and extension rules to the MMIO range (addr < 0x80000000) as to RAM.

Reset
REQ-022 SHALL, while rst_n=0, force state=IDLE, with every output 0 except req_ready=1.
REQ-023 SHALL abandon any in-flight request on reset assertion in any state, with no rsp_valid and no further dm_memread/dm_memwrite.
REQ-024 SHALL resume accepting requests on the first clk edge after rst_n deasserts.

Verification
REQ-025 SW 0x80000010 data 0xDEADBEEF -> one-cycle dm_memwrite with dm_datatype=2 and dm_addr=0x80000010; rsp_valid 2 cycles after accept, rsp_err=0.
REQ-026 With dm_rdata=0xDEADBEEF: LB 0x80000013 -> rsp_data=0xFFFFFFDE; LBU 0x80000013 -> 0x000000DE; LHU 0x80000012 -> 0x0000DEAD; LH 0x80000010 -> 0xFFFFBEEF; each 3 cycles after accept.
REQ-027 LW 0x80000002, LH 0x80000001, and funct3=011 load -> rsp_err=1, rsp_data=0, rsp_valid 1 cycle after accept, dm_memread never asserted.
REQ-028 LW 0x00100000 with dm_rdata=0x0126077C, rd=5 -> rsp_data=0x0126077C, rsp_rd=5.
REQ-029 Two loads with req_valid held high -> second accepted only on the edge after RESP; exactly one dm_memread pulse per load.
REQ-030 rst_n low during WAIT -> no rsp_valid; all outputs 0 and req_ready=1 immediately; a following LW completes normally.
